mem_port_arbiter: RTL and testbench

//  Shares one single-port behavioural memory (wen/a/d/q, combinational read) between two requesters.

---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/mem_port_arbiter_rr_arb2.sv | 32 +++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port memory arbiter: port indices,
// the registered response record and the address legality check.
package mem_arb_pkg;

    localparam int PORT_IMEM = 0;
    localparam int PORT_DMEM = 1;

    // Response data field width; must be at least the arbiter's BITS.
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    localparam rsp_t RSP_IDLE = '0;

    // Legal when word-aligned and inside [base, base + 4*depth). The offset is
    // taken modulo 2**bits so an address below base wraps high and fails.
    function automatic logic addr_ok(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int          depth,
        input int          bits
    );
        logic [63:0] mask;
        logic [63:0] diff;
        mask = (bits >= 64) ? '1 : ((64'd1 << bits) - 64'd1);
        diff = (addr - base) & mask;
        return (diff < (64'(depth) << 2)) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the port that did not win the last
// accepted request is granted; the history only moves when a grant is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 1 means port 1 won last, so port 0 takes the first contest after reset.
    logic r_last_grant;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (advance) begin
            r_last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port combinational-read memory between instruction fetch
// (port 0) and data access (port 1) with round-robin grant and 1-cycle responses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          BITS       = 32,
    parameter int          WORD_DEPTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic            req0_wen,
    input  logic [BITS-1:0] req0_addr,
    input  logic [BITS-1:0] req0_wdata,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [BITS-1:0] rsp0_rdata,
    output logic            rsp0_err,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_wen,
    input  logic [BITS-1:0] req1_addr,
    input  logic [BITS-1:0] req1_wdata,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [BITS-1:0] rsp1_rdata,
    output logic            rsp1_err,

    output logic            mem_wen,
    output logic [BITS-1:0] mem_a,
    output logic [BITS-1:0] mem_d,
    input  logic [BITS-1:0] mem_q,
    output logic [31:0]     mem_offset
);

    // Handshake: a request is accepted on a rising edge where valid && ready;
    // ready is only raised for the granted port, and only when its response
    // slot is empty or being consumed on that same edge. A response is
    // consumed on an edge where valid && ready and holds stable otherwise.

    rsp_t            r_rsp [2];

    logic [1:0]      w_valid;
    logic [1:0]      w_rsp_ready;
    logic [1:0]      w_elig;
    logic [1:0]      w_req;
    logic [1:0]      w_gnt;
    logic            w_any;
    logic            w_sel;
    logic            w_wen_sel;
    logic [BITS-1:0] w_addr_sel;
    logic [BITS-1:0] w_wdata_sel;
    logic            w_ok;
    logic            w_legal_read;
    rsp_t            w_load;

    assign w_valid     = {req1_valid, req0_valid};
    assign w_rsp_ready = {rsp1_ready, rsp0_ready};

    always_comb begin
        w_elig = 2'b00;
        for (int n = 0; n < 2; n++) begin
            w_elig[n] = !r_rsp[n].valid || w_rsp_ready[n];
        end
    end

    assign w_req = w_valid & w_elig;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_req),
        .advance (w_any),
        .gnt     (w_gnt)
    );

    assign w_any       = |w_gnt;
    assign w_sel       = w_gnt[PORT_DMEM];
    assign w_wen_sel   = w_sel ? req1_wen   : req0_wen;
    assign w_addr_sel  = w_sel ? req1_addr  : req0_addr;
    assign w_wdata_sel = w_sel ? req1_wdata : req0_wdata;

    assign w_ok         = addr_ok(64'(w_addr_sel), 64'(BASE_ADDR), WORD_DEPTH, BITS);
    assign w_legal_read = w_ok && !w_wen_sel;

    assign req0_ready = w_gnt[PORT_IMEM];
    assign req1_ready = w_gnt[PORT_DMEM];

    // Errored writes never reach the memory; idle cycles park the bus at word 0.
    assign mem_wen    = w_any && w_wen_sel && w_ok;
    assign mem_a      = w_any ? w_addr_sel : BITS'(BASE_ADDR);
    assign mem_d      = w_any ? w_wdata_sel : '0;
    assign mem_offset = BASE_ADDR;

    always_comb begin
        w_load       = RSP_IDLE;
        w_load.valid = 1'b1;
        w_load.err   = !w_ok;
        w_load.rdata = w_legal_read ? DATA_W'(mem_q) : '0;
    end

    // A new acceptance overwrites a slot that is being consumed on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 2; n++) begin
                r_rsp[n] <= RSP_IDLE;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_gnt[n]) begin
                    r_rsp[n] <= w_load;
                end else if (w_rsp_ready[n]) begin
                    r_rsp[n] <= RSP_IDLE;
                end
            end
        end
    end

    assign rsp0_valid = r_rsp[PORT_IMEM].valid;
    assign rsp0_err   = r_rsp[PORT_IMEM].err;
    assign rsp0_rdata = BITS'(r_rsp[PORT_IMEM].rdata);
    assign rsp1_valid = r_rsp[PORT_DMEM].valid;
    assign rsp1_err   = r_rsp[PORT_DMEM].err;
    assign rsp1_rdata = BITS'(r_rsp[PORT_DMEM].rdata);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a queue-based transaction model
// with its own copy of the memory contents.
module tb_mem_port_arbiter;

    localparam int          BITS  = 32;
    localparam int          DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0_valid = 0, req0_wen = 0, rsp0_ready = 0;
    logic        req1_valid = 0, req1_wen = 0, rsp1_ready = 0;
    logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_wen;
    logic [31:0] mem_a, mem_d, mem_q, mem_offset;

    mem_port_arbiter #(.BITS(BITS), .WORD_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wen(req0_wen),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wen(req1_wen),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q),
        .mem_offset(mem_offset)
    );

    // Behavioural memory attached to the DUT; preloaded through a clocked port.
    logic [31:0] tb_mem [DEPTH];
    logic        ld_en = 0;
    logic [4:0]  ld_idx = 0;
    logic [31:0] ld_val = 0;
    logic [31:0] mem_word;

    always_comb begin
        mem_word = (mem_a - mem_offset) >> 2;
        mem_q    = (mem_word < DEPTH) ? tb_mem[mem_word[4:0]] : 32'h0;
    end

    always @(posedge clk) begin
        if (ld_en) tb_mem[ld_idx] <= ld_val;
        else if (mem_wen && mem_word < DEPTH) tb_mem[mem_word[4:0]] <= mem_d;
    end

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    int          last_win;
    logic [1:0]  pv, pw, rr;
    logic [31:0] pa [2];
    logic [31:0] pd [2];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic legal(input logic [31:0] addr);
        longint unsigned a, lo, hi;
        a  = longint'(addr);
        lo = longint'(BASE);
        hi = lo + 4 * DEPTH;
        return (addr % 4 == 0) && a >= lo && a < hi;
    endfunction

    task automatic drive();
        req0_valid = pv[0]; req0_wen = pw[0]; req0_addr = pa[0]; req0_wdata = pd[0];
        req1_valid = pv[1]; req1_wen = pw[1]; req1_addr = pa[1]; req1_wdata = pd[1];
        rsp0_ready = rr[0]; rsp1_ready = rr[1];
    endtask

    // One clock: drive, check grant and memory bus, advance model, check responses.
    task automatic step();
        int          win;
        logic [1:0]  has, elig;
        logic        ok;
        logic [31:0] rdata, idx;
        drive();
        has[0] = exp_q0.size() != 0;
        has[1] = exp_q1.size() != 0;
        #1;
        for (int n = 0; n < 2; n++) elig[n] = pv[n] && (!has[n] || rr[n]);
        win = -1;
        if (elig == 2'b11) win = (last_win == 1) ? 0 : 1;
        else if (elig[0])  win = 0;
        else if (elig[1])  win = 1;
        check_eq("req0_ready", 32'(req0_ready), 32'(win == 0));
        check_eq("req1_ready", 32'(req1_ready), 32'(win == 1));
        ok = 1'b0;
        if (win >= 0) begin
            ok = legal(pa[win]);
            check_eq("mem_wen", 32'(mem_wen), 32'(pw[win] && ok));
            check_eq("mem_a", mem_a, pa[win]);
            check_eq("mem_d", mem_d, pd[win]);
        end else begin
            check_eq("mem_wen_idle", 32'(mem_wen), 32'h0);
            check_eq("mem_a_idle", mem_a, BASE);
            check_eq("mem_d_idle", mem_d, 32'h0);
        end
        @(posedge clk);
        if (has[0] && rr[0]) void'(exp_q0.pop_front());
        if (has[1] && rr[1]) void'(exp_q1.pop_front());
        if (win >= 0) begin
            idx   = (pa[win] - BASE) / 4;
            rdata = (ok && !pw[win]) ? ref_mem[idx[4:0]] : 32'h0;
            if (win == 0) exp_q0.push_back({!ok, rdata});
            else          exp_q1.push_back({!ok, rdata});
            if (ok && pw[win]) ref_mem[idx[4:0]] = pd[win];
            pv[win]  = 1'b0;
            last_win = win;
        end
        @(negedge clk);
        check_eq("rsp0_valid", 32'(rsp0_valid), 32'(exp_q0.size() != 0));
        if (exp_q0.size() != 0) begin
            check_eq("rsp0_err", 32'(rsp0_err), 32'(exp_q0[0][32]));
            check_eq("rsp0_rdata", rsp0_rdata, exp_q0[0][31:0]);
        end
        check_eq("rsp1_valid", 32'(rsp1_valid), 32'(exp_q1.size() != 0));
        if (exp_q1.size() != 0) begin
            check_eq("rsp1_err", 32'(rsp1_err), 32'(exp_q1[0][32]));
            check_eq("rsp1_rdata", rsp1_rdata, exp_q1[0][31:0]);
        end
    endtask

    task automatic set_req(input int n, input logic wen, input logic [31:0] addr, input logic [31:0] wdata);
        pv[n] = 1'b1; pw[n] = wen; pa[n] = addr; pd[n] = wdata;
    endtask

    task automatic gen_req(input int n);
        int kind;
        logic [31:0] a;
        kind = $urandom_range(0, 9);
        case (kind)
            0:       a = 32'h80 + 4 * $urandom_range(0, 63);
            1:       a = 4 * $urandom_range(0, 31) + $urandom_range(1, 3);
            2:       a = 32'hFFFF_FFFC;
            default: a = 4 * $urandom_range(0, 31);
        endcase
        set_req(n, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    task automatic reset_model();
        exp_q0.delete();
        exp_q1.delete();
        last_win = 1;
        pv = 2'b00; pw = 2'b00; rr = 2'b00;
        pa[0] = 0; pa[1] = 0; pd[0] = 0; pd[1] = 0;
    endtask

    initial begin
        reset_model();
        drive();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            ld_en  = 1'b1;
            ld_idx = 5'(i);
            ld_val = (i == 1) ? 32'hDEAD_BEEF : $urandom;
            ref_mem[i] = ld_val;
        end
        @(negedge clk);
        ld_en = 1'b0;
        check_eq("rst_rsp0_valid", 32'(rsp0_valid), 32'h0);
        check_eq("rst_rsp0_err", 32'(rsp0_err), 32'h0);
        check_eq("rst_rsp0_rdata", rsp0_rdata, 32'h0);
        check_eq("rst_rsp1_valid", 32'(rsp1_valid), 32'h0);
        check_eq("rst_rsp1_err", 32'(rsp1_err), 32'h0);
        check_eq("rst_rsp1_rdata", rsp1_rdata, 32'h0);
        check_eq("mem_offset", mem_offset, BASE);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read of word 1, then both ports contending with free slots.
        rr = 2'b11;
        set_req(0, 1'b0, 32'h4, 32'h0);
        step();
        check_eq("first_read_data", rsp0_rdata, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b0, 4 * $urandom_range(0, 31), 32'h0);
            set_req(1, 1'b0, 4 * $urandom_range(0, 31), 32'h0);
            step();
        end
        while (pv != 2'b00) step();

        // Write then read back through the other port.
        set_req(1, 1'b1, 32'h8, 32'h1234);
        step();
        set_req(0, 1'b0, 32'h8, 32'h0);
        step();
        check_eq("readback_0x8", rsp0_rdata, 32'h1234);

        // Out-of-window and misaligned writes.
        set_req(1, 1'b1, 32'h80, 32'hAAAA_5555);
        step();
        set_req(1, 1'b1, 32'h6, 32'h5555_AAAA);
        step();

        // Port 0 response stalled while port 1 keeps getting granted.
        rr = 2'b10;
        set_req(0, 1'b0, 32'hC, 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b0, 32'h10, 32'h0);
            set_req(1, 1'b0, 4 * $urandom_range(0, 31), 32'h0);
            step();
        end
        rr = 2'b11;
        while (pv != 2'b00) step();

        // Randomized traffic with random response back-pressure.
        for (int k = 0; k < 600; k++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pv[n] && $urandom_range(0, 3) != 0) gen_req(n);
                rr[n] = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        // Reset with responses pending: they vanish, port 0 wins the next tie.
        rr = 2'b00;
        pv = 2'b00;
        set_req(0, 1'b0, 32'h4, 32'h0);
        set_req(1, 1'b0, 32'h8, 32'h0);
        step();
        pv = 2'b00;
        drive();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_rsp0_valid", 32'(rsp0_valid), 32'h0);
        check_eq("midrst_rsp1_valid", 32'(rsp1_valid), 32'h0);
        reset_model();
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        rr = 2'b11;
        set_req(0, 1'b0, 32'h4, 32'h0);
        set_req(1, 1'b0, 32'h8, 32'h0);
        step();
        check_eq("post_rst_rsp0_valid", 32'(rsp0_valid), 32'h1);
        while (pv != 2'b00) step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
